mi_arbiter: RTL
===============

# mi_arbiter

Two-port arbiter for the PSRAM memory-interface (`mi_*`) protocol. It sits between the memory controller and two requesters: port 0 is the HDMI scan-out DMA, and port 1 is the general-purpose CPU/loader port. It serializes whole transactions, meaning the request plus its complete read or write data phase. It routes per-word data strobes only to the granted requester.

## Interface
- `RR`, default 0: arbitration mode. 0 = fixed priority, port 0 wins. 1 = round-robin, the last-served port loses a tie.
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `sN_addr`  in  23  word address; N = 0, 1 for every `sN_` port
- `sN_len`  in  7  burst length minus one
- `sN_rw`  in  1  1 = read, 0 = write
- `sN_valid`  in  1  request valid
- `sN_ready`  out  1  request accepted
- `sN_wdata`  in  16  write data
- `sN_wack`  out  1  write word consumed
- `sN_wlast`  out  1  last write word, qualified by `sN_wack`
- `sN_rdata`  out  16  read data, broadcast
- `sN_rstb`  out  1  read word valid
- `sN_rlast`  out  1  last read word, qualified by `sN_rstb`
- `m_addr`, `m_len`, `m_rw`, `m_valid`  out  23/7/1/1  to controller
- `m_ready`  in  1  controller accept
- `m_wdata`  out  16; `m_wack`, `m_wlast`  in  1  write data path
- `m_rdata`  in  16; `m_rstb`, `m_rlast`  in  1  read data path

## Operation
- State machine with three states.
  - IDLE: no grant. If any `sN_valid` is high, register `gnt` and move to REQ.
  - REQ: forward the granted port to the controller.
  - DATA: wait for the transaction's last word.
- Grant selection in IDLE:
  - `RR`=0: port 0 if `s0_valid`, else port 1.
  - `RR`=1: if both ports are valid, grant the port other than `last_gnt`; otherwise grant the single valid one.
  - `last_gnt` updates on every request handshake. Its reset value is 1, so port 0 wins the first tie.
- REQ:
  - `m_addr`, `m_len`, `m_rw` are muxed from `gnt`.
  - `m_valid` = `s[gnt]_valid`.
  - `s[gnt]_ready` = `m_ready`. The non-granted `ready` is 0.
  - On `m_valid & m_ready`: capture `rw` into `cur_rw` and go to DATA.
  - If `s[gnt]_valid` drops before acceptance (for example, DMA stopped): return to IDLE. Nothing is forwarded.
- DATA:
  - Read (`cur_rw`=1): `s[gnt]_rstb` = `m_rstb`, `s[gnt]_rlast` = `m_rlast`. Exit to IDLE on `m_rstb & m_rlast`.
  - Write (`cur_rw`=0): `m_wdata` = `s[gnt]_wdata`, `s[gnt]_wack` = `m_wack`, `s[gnt]_wlast` = `m_wlast`. Exit on `m_wack & m_wlast`.
  - `m_valid` = 0 throughout DATA, so only one transaction is outstanding.
- Strobe gating:
  - `sN_rdata` = `m_rdata` on both ports, unregistered.
  - Strobes to the non-granted port are always 0.
  - Strobes arriving in IDLE or REQ are dropped. The controller guarantees data only after acceptance.
- `m_wdata` = `s[gnt]_wdata` in all states, for zero-latency write feed.

## Timing
- Reset:
  - State = IDLE, `gnt` = 0, `last_gnt` = 1, `cur_rw` = 1.
  - All `ready`/`valid`/strobe outputs are 0.
  - `m_addr`/`m_len` carry the port-0 mux value. Don't-care while `m_valid` = 0.
- Reset mid-transaction: abort immediately to IDLE. In-flight controller strobes are dropped.
- Arbitration latency: `sN_valid` rising in IDLE at cycle T gives `m_valid` = 1 at T+1. `sN_ready` is combinational from `m_ready`.
- Back-to-back: the last-word cycle T returns to IDLE at T+1. The next `m_valid` is at T+2 at the earliest.
- All request/data muxes are combinational from registered state; no added data latency.
- A last strobe and new `valid` in the same cycle: the new request is only evaluated in IDLE.
- `m_len` is passed unmodified. The arbiter does no counting and relies on `rlast`/`wlast`.

## Test plan
- Single read, port 0: `s0` addr=0x000100, len=3, rw=1. Controller returns 4 `rstb`, `rlast` on the 4th. Expect 4 `s0_rstb`, 0 `s1_rstb`, and return to IDLE.
- Simultaneous, `RR`=0: both ports valid three times in a row. Expect port 0 served all three times; port 1 served only once `s0_valid` stays low.
- Simultaneous, `RR`=1: both ports persistently valid. Expect the grant order 0, 1, 0, 1.
- Write, port 1: len=7, rw=0, `s1_wdata` = 0xA5A0+i. Expect `m_wdata` to match on each of 8 `m_wack`, `s1_wlast` on the 8th, and `s0_wack` always 0.
- Withdrawn request: `s0_valid` high 1 cycle with `m_ready` = 0, then low. Expect `m_valid` to fall and IDLE reached, with no `s0_ready`.
- Reset mid-read: assert `rst` after 2 of 64 words. Expect outputs 0 immediately, and a post-reset port-1 request granted normally.

Source files
------------

// File: rtl/mi_arbiter.sv
// mi_arbiter: two-port whole-transaction arbiter for the PSRAM mi_* interface
module mi_arbiter #(
   parameter bit RR = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [22:0] s0_addr,
   input  logic [6:0]  s0_len,
   input  logic        s0_rw,
   input  logic        s0_valid,
   output logic        s0_ready,
   input  logic [15:0] s0_wdata,
   output logic        s0_wack,
   output logic        s0_wlast,
   output logic [15:0] s0_rdata,
   output logic        s0_rstb,
   output logic        s0_rlast,
   input  logic [22:0] s1_addr,
   input  logic [6:0]  s1_len,
   input  logic        s1_rw,
   input  logic        s1_valid,
   output logic        s1_ready,
   input  logic [15:0] s1_wdata,
   output logic        s1_wack,
   output logic        s1_wlast,
   output logic [15:0] s1_rdata,
   output logic        s1_rstb,
   output logic        s1_rlast,
   output logic [22:0] m_addr,
   output logic [6:0]  m_len,
   output logic        m_rw,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [15:0] m_wdata,
   input  logic        m_wack,
   input  logic        m_wlast,
   input  logic [15:0] m_rdata,
   input  logic        m_rstb,
   input  logic        m_rlast
);
   typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
   state_t state, state_d;
   logic gnt, gnt_d, last_gnt, last_gnt_d, cur_rw, cur_rw_d;
   logic sel_valid, sel_rw, pick, req, rd_en, wr_en;
   assign sel_valid = gnt ? s1_valid : s0_valid;
   assign sel_rw    = gnt ? s1_rw : s0_rw;
   assign pick      = RR ? ((s0_valid & s1_valid) ? ~last_gnt : s1_valid) : ~s0_valid;
   // state, grant and transaction-direction registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         gnt      <= 1'b0;
         last_gnt <= 1'b1;
         cur_rw   <= 1'b1;
      end else begin
         state    <= state_d;
         gnt      <= gnt_d;
         last_gnt <= last_gnt_d;
         cur_rw   <= cur_rw_d;
      end
   // next state: grant in IDLE, forward in REQ, wait for the last word in DATA
   always_comb begin
      state_d    = state;
      gnt_d      = gnt;
      last_gnt_d = last_gnt;
      cur_rw_d   = cur_rw;
      if (state == IDLE) begin
         if (s0_valid | s1_valid) begin
            state_d = REQ;
            gnt_d   = pick;
         end
      end else if (state == REQ) begin
         if (!sel_valid) state_d = IDLE;
         else if (m_ready) begin
            state_d    = DATA;
            cur_rw_d   = sel_rw;
            last_gnt_d = gnt;
         end
      end else if (cur_rw ? (m_rstb & m_rlast) : (m_wack & m_wlast)) state_d = IDLE;
   end
   assign req   = state == REQ;
   assign rd_en = (state == DATA) & cur_rw;
   assign wr_en = (state == DATA) & ~cur_rw;
   assign m_addr   = gnt ? s1_addr : s0_addr;
   assign m_len    = gnt ? s1_len : s0_len;
   assign m_rw     = sel_rw;
   assign m_valid  = req & sel_valid;
   assign m_wdata  = gnt ? s1_wdata : s0_wdata;
   assign s0_ready = req & ~gnt & m_ready;
   assign s1_ready = req & gnt & m_ready;
   assign s0_rdata = m_rdata;
   assign s1_rdata = m_rdata;
   assign s0_rstb  = rd_en & ~gnt & m_rstb;
   assign s1_rstb  = rd_en & gnt & m_rstb;
   assign s0_rlast = rd_en & ~gnt & m_rlast;
   assign s1_rlast = rd_en & gnt & m_rlast;
   assign s0_wack  = wr_en & ~gnt & m_wack;
   assign s1_wack  = wr_en & gnt & m_wack;
   assign s0_wlast = wr_en & ~gnt & m_wlast;
   assign s1_wlast = wr_en & gnt & m_wlast;
endmodule
